sqrt_seed_arbiter: RTL
======================

# sqrt_seed_arbiter

Shares one leading-one locator between NUM_REQ requesters, such as the ray-normalisation and distance units, that each need a square-root seed for a fixed-point operand. It accepts one request at a time under round-robin arbitration and locates the most significant set bit of the operand's integer part. It returns the ceiling of half that bit index, the exponent of the initial square-root guess, over a valid/ready response channel. The block sits between the requesting units and their Newton-iteration stages.

## Interface
- WIDTH, 12, total operand width; the low FRAC_BITS bits are fraction.
- FRAC_BITS, 4, number of fractional bits, discarded before the search.
- NUM_REQ, 4, number of requesters; minimum 2.
- LOC_W, 6, width of the location result.
- ID_W, $clog2(NUM_REQ), width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request; must be held until the matching req_ready is seen.
- req_vector  input  NUM_REQ*WIDTH  operands; requester k occupies bits [k*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot accept strobe; combinational from the state and grant.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_location  output  LOC_W  ceil(msb_index/2) of the integer part.
- rsp_zero  output  1  the integer part was all zero; rsp_location is 0 in that case.

## Operation
- The state machine has three states: IDLE, LOCATE and RESPOND.
- IDLE:
  - If any req_valid is high, grant the first requester at or after rr_ptr, searching upward with wrap-around.
  - Drive req_ready[grant]=1 in that cycle and latch req_vector[grant] and the grant index.
  - Move to LOCATE.
  - If no request is pending, stay in IDLE with req_ready all zero.
- LOCATE:
  - Compute int = latched_vector >> FRAC_BITS, which is WIDTH-FRAC_BITS bits wide.
  - Set i to the index of the highest set bit of int.
  - If i is odd, location = (i+1)>>1; if i is even, location = i>>1.
  - If int == 0, rsp_zero=1 and location=0.
  - Register the results into the rsp_* outputs and move to RESPOND.
- RESPOND:
  - Hold rsp_valid=1 with rsp_id, rsp_location and rsp_zero stable until rsp_ready=1.
  - On the handshake cycle, set rsp_valid to 0 in the next cycle, set rr_ptr = (grant+1) mod NUM_REQ, and return to IDLE.
- New requests are granted only in IDLE. While the block is in LOCATE or RESPOND, req_ready stays all zero.
- rr_ptr advances only on a completed response, so the grant sequence is fair.
- Reset value of every output: req_ready=0, rsp_valid=0, rsp_id=0, rsp_location=0, rsp_zero=0. Internal reset values: state=IDLE, rr_ptr=0.
- Reset mid-operation: the in-flight transaction is dropped and no response is produced. The requester must re-issue the request after reset.
- Dropping req_valid before the accept is a protocol violation. Its behaviour is undefined and the bench asserts against it.

## Timing
- Accept cycle N, when req_ready is high → LOCATE in cycle N+1 → rsp_valid high from cycle N+2.
- Minimum spacing between accepts is 3 cycles, when rsp_ready is already high at N+2.
- Backpressure: each cycle with rsp_ready low at RESPOND adds one cycle. There is no timeout.
- Simultaneous requests are resolved by round-robin in a single cycle. A requester that is not granted waits at most NUM_REQ-1 transactions.
- Elaboration asserts WIDTH > FRAC_BITS and 2^LOC_W > (WIDTH-FRAC_BITS)/2.

## Structure
- Shared package sqrt_seed_pkg holds:
  - the state enum typedef (IDLE, LOCATE, RESPOND);
  - default constants FRAC_BITS=4 and LOC_W=6, reused by the Newton stages.
- One sub-module, lead_one_locate: purely combinational, parameterised by WIDTH and FRAC_BITS. It takes the vector and produces location and zero, using a priority encode followed by the ceiling halving. The arbiter registers its outputs in LOCATE.
- The round-robin grant logic stays inline as a rotate, priority-pick and rotate-back.

## Test plan
- Single requester 0, vector 12'h0F0 (int=15, i=3) → rsp_valid at N+2, rsp_id=0, rsp_location=2, rsp_zero=0.
- Boundary operands, one per request:
  - 12'h00F → rsp_zero=1, location=0.
  - 12'h010 → i=0, location=0, rsp_zero=0.
  - 12'h040 → location=1.
  - 12'hFFF → i=7, location=4.
- All four requesters valid from reset with rsp_ready tied high → grants 0,1,2,3,0 in order, accepts exactly 3 cycles apart.
- rsp_ready held low for 5 cycles in RESPOND → rsp_valid and rsp_* outputs are stable, req_ready stays zero, and the next grant follows the handshake.
- rst_ asserted in LOCATE, with requester 2's operand latched → all outputs go to zero asynchronously, no response is produced, and the first grant after release goes to requester 0.
- Requester 1 alone issues back-to-back requests while requesters 0, 2 and 3 are idle → every request goes to requester 1, with rr_ptr wrapping correctly.

Source files
------------

// File: rtl/sqrt_seed_pkg.sv
// rtl/sqrt_seed_pkg.sv - shared state type and default sizing for the sqrt seed path
package sqrt_seed_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCATE  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Defaults shared with the downstream Newton stages
   localparam int DEFAULT_FRAC_BITS = 4;
   localparam int DEFAULT_LOC_W     = 6;

endpackage

// File: rtl/lead_one_locate.sv
// rtl/lead_one_locate.sv - leading-one search on the integer part with ceiling halving
module lead_one_locate
   import sqrt_seed_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
   parameter int LOC_W     = DEFAULT_LOC_W
) (
   input  logic [WIDTH-1:0] vector,
   output logic [LOC_W-1:0] location,
   output logic             zero
);

   logic [WIDTH-1:0] int_part;
   int unsigned      msb;

   // Priority-encode the highest set bit of the integer part, then halve it rounding up
   always_comb begin
      int_part = vector >> FRAC_BITS;
      msb      = 0;
      zero     = 1'b1;
      for (int b = 0; b < WIDTH; b++) begin
         if (int_part[b]) begin
            msb  = unsigned'(b);
            zero = 1'b0;
         end
      end
      location = zero ? '0 : LOC_W'((msb + 1) >> 1);
   end

endmodule

// File: rtl/sqrt_seed_arbiter.sv
// rtl/sqrt_seed_arbiter.sv - round-robin shared leading-one locator for sqrt seeds
module sqrt_seed_arbiter
   import sqrt_seed_pkg::*;
#(
   parameter int WIDTH     = 12,
   parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
   parameter int NUM_REQ   = 4,
   parameter int LOC_W     = DEFAULT_LOC_W,
   parameter int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_vector,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [LOC_W-1:0]         rsp_location,
   output logic                     rsp_zero
);

   if (WIDTH <= FRAC_BITS) begin : g_bad_frac
      $error("sqrt_seed_arbiter: WIDTH must exceed FRAC_BITS");
   end
   if ((1 << LOC_W) <= ((WIDTH - FRAC_BITS) / 2)) begin : g_bad_loc
      $error("sqrt_seed_arbiter: LOC_W too narrow for the location range");
   end
   if (NUM_REQ < 2) begin : g_bad_req
      $error("sqrt_seed_arbiter: NUM_REQ must be at least 2");
   end

   state_t              state;
   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     grant_id;
   logic [WIDTH-1:0]    lat_vec;
   logic [NUM_REQ-1:0]  rot_valid;
   logic [ID_W-1:0]     rot_pick;
   logic [ID_W:0]       grant_sum;
   logic [ID_W-1:0]     grant;
   logic                any_req;
   logic [LOC_W-1:0]    loc;
   logic                loc_zero;

   // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest request, rotate back
   always_comb begin
      rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
      rot_pick  = '0;
      any_req   = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot_valid[k]) begin
            rot_pick = ID_W'(k);
            any_req  = 1'b1;
         end
      end
      grant_sum = {1'b0, rot_pick} + {1'b0, rr_ptr};
      grant     = (grant_sum >= (ID_W+1)'(NUM_REQ)) ?
                  ID_W'(grant_sum - (ID_W+1)'(NUM_REQ)) : grant_sum[ID_W-1:0];
   end

   // Accept strobe only in IDLE; held low while reset is asserted so no request is taken
   always_comb begin
      req_ready = '0;
      if (rst_ && (state == IDLE) && any_req) begin
         req_ready[grant] = 1'b1;
      end
   end

   lead_one_locate #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .LOC_W     (LOC_W)
   ) u_locate (
      .vector   (lat_vec),
      .location (loc),
      .zero     (loc_zero)
   );

   // Accept, locate and respond sequencing; rr_ptr moves only after a completed response
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         lat_vec      <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= '0;
         rsp_location <= '0;
         rsp_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  lat_vec  <= req_vector[grant*WIDTH +: WIDTH];
                  grant_id <= grant;
                  state    <= LOCATE;
               end
            end
            LOCATE: begin
               rsp_id       <= grant_id;
               rsp_location <= loc;
               rsp_zero     <= loc_zero;
               rsp_valid    <= 1'b1;
               state        <= RESPOND;
            end
            RESPOND: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rr_ptr    <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
